// File: rtl/serial_add_pkg.sv
// Shared FSM state encoding and small helpers for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_add_pkg;

  // Two-bit state encoding; the fourth code is unreachable and recovers to IDLE.
  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Legal operand width range.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bit-counter width for a given operand width. The legal range starts at 2,
  // so $clog2 never returns 0 here. The clamp keeps an illegal width from
  // producing a zero-width vector before the range check in the top fires.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder, gate-level XOR sum and AND/OR majority carry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always valid for the current inputs.
//
// Ports:
//   a, b   - operand bits
//   c_in   - carry into this bit position
//   s      - sum bit
//   c_out  - carry out of this bit position
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic ab_x;
  logic ab_a;
  logic ac_a;
  logic bc_a;

  assign ab_x  = a ^ b;
  assign s     = ab_x ^ c_in;

  // Carry is the majority of the three inputs.
  assign ab_a  = a & b;
  assign ac_a  = a & c_in;
  assign bc_a  = b & c_in;
  assign c_out = ab_a | ac_a | bc_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is only sampled while ready=1; RUN/DONE ignore all inputs.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - begin an addition (sampled only in IDLE)
//   a, b   - addends, captured on the accepting edge
//   c_in   - carry-in, captured on the accepting edge
//   ready  - high in IDLE only
//   busy   - high in RUN only
//   done   - one-cycle pulse in DONE
//   s      - sum, held from DONE until the next accepted start
//   c_out  - final carry-out, only written on the last bit
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  import serial_add_pkg::*;

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // Elaboration-time guard on the operand width.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  // The only arithmetic in the design: fed from the operand LSBs and the
  // carry flop every cycle; its outputs are only consumed in RUN.
  fa_cell u_fa (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  assign last_bit = (cnt == LAST);

  // Status outputs decode straight from the state register so that reset
  // forces them without waiting for a clock edge.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands in s[0].
          s     <= {fa_s, s[WIDTH-1:1]};
          carry <= fa_c;
          if (last_bit) begin
            // Counter saturates on the final bit instead of wrapping, and
            // c_out keeps the previous result until this edge.
            c_out <= fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // DONE and the unreachable code leave the datapath untouched so
          // the result is held.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random self-checking bench for serial_add_ctrl at WIDTH=8.
// Latency: checks done arrives exactly WIDTH cycles after the accepting edge.
// Backpressure: waits for ready (bounded) before each start.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;
  logic last_c = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exactly one of ready/busy/done every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("excl", 32'($countones({ready, busy, done})), 32'd1);
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_to"}, 32'(ready), 32'd1);
  endtask

  // One full addition. With scramble set, the inputs are trashed during
  // RUN and start is held into DONE, which must not re-trigger.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input bit scramble, input bit quiet);
    int n;
    wait_ready(tag);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    tick();
    if (scramble) begin
      a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
    end else begin
      start = 1'b0; a = ~ta; b = ~tb_v; c_in = ~tc;
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1 && !quiet) begin
        check({tag, "_cout_early"}, 32'(c_out), 32'(last_c));
      end
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
    tick();
    if (scramble) begin
      check({tag, "_start_in_done_ignored"}, 32'(ready), 32'd1);
      start = 1'b0;
    end
    if (!quiet) begin
      check({tag, "_hold_s"}, 32'(s), 32'(es));
      check({tag, "_hold_cout"}, 32'(c_out), 32'(ec));
    end
    last_c = ec;
  endtask

  initial begin
    int t[3];
    int nd;
    int cyc;
    int seen;
    logic [W:0] exp_sum;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    // Reset state
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_s",     32'(s),     32'd0);
    check("rst_cout",  32'(c_out), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Basic carry ripple through all bits
    run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Carry-in propagation, then a result with no carry; hold in between
    run_add("5a_a5", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    a = 8'h77; b = 8'h88; c_in = 1'b1;
    repeat (3) tick();
    check("idle_hold_s", 32'(s), 32'h00);
    check("idle_hold_cout", 32'(c_out), 32'd1);
    run_add("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high
    wait_ready("cont");
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done === 1'b1) begin
        t[nd] = cyc;
        check("cont_s", 32'(s), 32'h02);
        nd++;
      end
    end
    start = 1'b0;
    check("cont_ndone", 32'(nd), 32'd3);
    check("cont_period1", 32'(t[1] - t[0]), 32'd10);
    check("cont_period2", 32'(t[2] - t[1]), 32'd10);
    last_c = 1'b0;

    // Input changes during RUN/DONE must not disturb the operation
    run_add("scramble", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);

    // Async reset mid-RUN
    wait_ready("rstmid");
    a = 8'hF0; b = 8'h0F; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rstmid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_ready", 32'(ready), 32'd1);
    check("rstmid_busyq", 32'(busy),  32'd0);
    check("rstmid_done",  32'(done),  32'd0);
    check("rstmid_s",     32'(s),     32'd0);
    check("rstmid_cout",  32'(c_out), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("rstmid_nodone", 32'(seen), 32'd0);
    last_c = 1'b0;
    run_add("after_rst", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random triples against integer addition
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_add("rand", ra, rb, rc, exp_sum[W-1:0], exp_sum[W], 1'b0, 1'b1);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
